// File: rtl/adder_arb_pkg.sv
// Shared types and constants for the adder_arb round-robin adder sequencer.
// Optional saturation is selected with the ADDER_ARB_SATURATE_EN macro (see adder_arb.sv).
package adder_arb_pkg;

  typedef enum logic {
    StEmpty = 1'b0,
    StFull  = 1'b1
  } state_e;

  localparam state_e RstState    = StEmpty;
  localparam logic   RstRspCarry = 1'b0;

  // Ceiling log2, used to cross-check the ID width against the requester count.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned v = 1; v < n; v = v << 1) begin
      r++;
    end
    return r;
  endfunction

endpackage

// File: rtl/adder_arb_rr_pick.sv
// Combinational round-robin picker: first requester strictly after last_grant_i,
// wrapping from N_REQ-1 to 0. Produces a one-hot grant plus its binary index.
module adder_arb_rr_pick #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned ID_W  = 2
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [ID_W-1:0]  last_grant_i,
  input  logic             en_i,
  output logic [N_REQ-1:0] gnt_o,
  output logic [ID_W-1:0]  idx_o
);

  logic            found;
  logic [ID_W-1:0] cand;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    cand  = '0;
    // Offsets 1..N_REQ visit every requester once, last_grant_i itself last.
    for (int unsigned off = 1; off <= N_REQ; off++) begin
      cand = ID_W'((32'(last_grant_i) + off) % N_REQ);
      if (en_i && !found && req_i[cand]) begin
        found       = 1'b1;
        gnt_o[cand] = 1'b1;
        idx_o       = cand;
      end
    end
  end

endmodule

// File: rtl/adder_arb.sv
// Round-robin arbiter sharing one ripple-carry adder among N_REQ requesters, with a
// single-entry result stage. Define ADDER_ARB_SATURATE_EN to clamp the sum on carry-out.
module adder_arb
  import adder_arb_pkg::*;
#(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned WIDTH = 4,
  parameter int unsigned ID_W  = 2
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [N_REQ-1:0]       i_req_valid,
  input  logic [N_REQ*WIDTH-1:0] i_req_a,
  input  logic [N_REQ*WIDTH-1:0] i_req_b,
  output logic [N_REQ-1:0]       o_req_ready,
  output logic                   o_rsp_valid,
  output logic [ID_W-1:0]        o_rsp_id,
  output logic [WIDTH-1:0]       o_rsp_sum,
  output logic                   o_rsp_carry,
  input  logic                   i_rsp_ready
);

  if (ID_W != clog2(N_REQ)) begin : gen_bad_id_w
    $error("adder_arb: ID_W must equal clog2(N_REQ)");
  end
  if (N_REQ < 2 || N_REQ > 8) begin : gen_bad_n_req
    $error("adder_arb: N_REQ must be in 2..8");
  end

  state_e            state_q, state_d;
  logic [ID_W-1:0]   last_grant_q, last_grant_d;
  logic [ID_W-1:0]   rsp_id_q, rsp_id_d;
  logic [WIDTH-1:0]  rsp_sum_q, rsp_sum_d;
  logic              rsp_carry_q, rsp_carry_d;

  logic              free;
  logic [N_REQ-1:0]  gnt;
  logic [ID_W-1:0]   gnt_idx;
  logic              gnt_any;
  logic [WIDTH-1:0]  sel_a, sel_b;
  logic [WIDTH-1:0]  sum_raw, sum_out;
  logic              ripple_c, carry_raw;

  // The slot is free when empty, or when the held result leaves this cycle.
  always_comb begin
    free = 1'b0;
    unique case (state_q)
      StEmpty: free = 1'b1;
      StFull:  free = i_rsp_ready;
      default: free = 1'b0;
    endcase
  end

  adder_arb_rr_pick #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_rr_pick (
    .req_i        (i_req_valid),
    .last_grant_i (last_grant_q),
    .en_i         (free),
    .gnt_o        (gnt),
    .idx_o        (gnt_idx)
  );

  assign gnt_any     = |gnt;
  assign o_req_ready = gnt;

  // Without a grant the mux still points at requester 0; the result is simply not stored.
  assign sel_a = i_req_a[gnt_idx*WIDTH +: WIDTH];
  assign sel_b = i_req_b[gnt_idx*WIDTH +: WIDTH];

  always_comb begin
    ripple_c = 1'b0;
    sum_raw  = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      sum_raw[i] = sel_a[i] ^ sel_b[i] ^ ripple_c;
      ripple_c   = (sel_a[i] & sel_b[i]) | (ripple_c & (sel_a[i] ^ sel_b[i]));
    end
    carry_raw = ripple_c;
  end

`ifdef ADDER_ARB_SATURATE_EN
  assign sum_out = carry_raw ? {WIDTH{1'b1}} : sum_raw;
`else
  assign sum_out = sum_raw;
`endif

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    rsp_id_d     = rsp_id_q;
    rsp_sum_d    = rsp_sum_q;
    rsp_carry_d  = rsp_carry_q;
    if (gnt_any) begin
      // Covers both a fresh fill and the accept-and-refill case.
      state_d      = StFull;
      last_grant_d = gnt_idx;
      rsp_id_d     = gnt_idx;
      rsp_sum_d    = sum_out;
      rsp_carry_d  = carry_raw;
    end else if (state_q == StFull && i_rsp_ready) begin
      state_d = StEmpty;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q      <= RstState;
      last_grant_q <= ID_W'(N_REQ - 1);
      rsp_id_q     <= '0;
      rsp_sum_q    <= '0;
      rsp_carry_q  <= RstRspCarry;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      rsp_id_q     <= rsp_id_d;
      rsp_sum_q    <= rsp_sum_d;
      rsp_carry_q  <= rsp_carry_d;
    end
  end

  assign o_rsp_valid = (state_q == StFull);
  assign o_rsp_id    = rsp_id_q;
  assign o_rsp_sum   = rsp_sum_q;
  assign o_rsp_carry = rsp_carry_q;

endmodule

// File: tb/tb_adder_arb.sv
// Self-checking bench for adder_arb: directed scenarios plus a randomized run,
// all checked against a queue-free behavioural model of the arbitration rules.
module tb_adder_arb;

  localparam int N = 4;
  localparam int W = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N*W-1:0]  req_a, req_b;
  logic [N-1:0]    req_ready;
  logic            rsp_valid;
  logic [1:0]      rsp_id;
  logic [W-1:0]    rsp_sum;
  logic            rsp_carry;
  logic            rsp_ready;

  int checks = 0;
  int passes = 0;

  // Behavioural model state
  int m_last;
  bit m_full;
  int m_id, m_sum, m_carry;

  always #5 clk = ~clk;

  adder_arb #(
    .N_REQ (N),
    .WIDTH (W),
    .ID_W  (2)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_req_valid (req_valid),
    .i_req_a     (req_a),
    .i_req_b     (req_b),
    .o_req_ready (req_ready),
    .o_rsp_valid (rsp_valid),
    .o_rsp_id    (rsp_id),
    .o_rsp_sum   (rsp_sum),
    .o_rsp_carry (rsp_carry),
    .i_rsp_ready (rsp_ready)
  );

  function automatic int pick(input logic [N-1:0] v, input int last);
    for (int off = 1; off <= N; off++) begin
      if (v[(last + off) % N]) return (last + off) % N;
    end
    return -1;
  endfunction

  function automatic int exp_grant();
    if (m_full && !rsp_ready) return -1;
    return pick(req_valid, m_last);
  endfunction

  function automatic logic [N-1:0] onehot(input int g);
    logic [N-1:0] v;
    v = '0;
    if (g >= 0) v[g] = 1'b1;
    return v;
  endfunction

  task automatic model_reset();
    m_last  = N - 1;
    m_full  = 0;
    m_id    = 0;
    m_sum   = 0;
    m_carry = 0;
  endtask

  // Applies one clock edge to the model, using the inputs present before the edge.
  task automatic model_edge(input int g);
    int s;
    if (g >= 0) begin
      s       = int'(req_a[g*W +: W]) + int'(req_b[g*W +: W]);
      m_carry = s / (1 << W);
      m_sum   = s % (1 << W);
`ifdef ADDER_ARB_SATURATE_EN
      if (m_carry != 0) m_sum = (1 << W) - 1;
`endif
      m_id   = g;
      m_last = g;
      m_full = 1;
    end else if (m_full && rsp_ready) begin
      m_full = 0;
    end
  endtask

  task automatic new_operands(input int k);
    req_a[k*W +: W] = W'($urandom);
    req_b[k*W +: W] = W'($urandom);
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    req_valid = '1;
    rsp_ready = 1'b1;
    for (int k = 0; k < N; k++) new_operands(k);
    req_a[0 +: W] = 4'd3;
    req_b[0 +: W] = 4'd4;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0) $display("FAIL reset_valid: got %0b expected 0", rsp_valid);
    else passes++;
    checks++;
    if ({rsp_id, rsp_sum, rsp_carry} !== '0)
      $display("FAIL reset_data: got id=%0d sum=%0d carry=%0b expected all zero",
               rsp_id, rsp_sum, rsp_carry);
    else passes++;
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_first_grant();
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0001) $display("FAIL first_grant: got %b expected 0001", req_ready);
    else passes++;
    @(posedge clk);
    #1 model_edge(0);
    checks++;
    if ({rsp_valid, rsp_id, rsp_sum, rsp_carry} !== {1'b1, 2'd0, 4'd7, 1'b0})
      $display("FAIL first_rsp: got v=%0b id=%0d sum=%0d c=%0b expected v=1 id=0 sum=7 c=0",
               rsp_valid, rsp_id, rsp_sum, rsp_carry);
    else passes++;
    new_operands(0);
  endtask

  task automatic test_round_robin();
    int order;
    req_valid = '1;
    rsp_ready = 1'b1;
    for (int c = 0; c < 9; c++) begin
      order = (m_last + 1) % N;
      @(negedge clk);
      checks++;
      if (req_ready !== onehot(order))
        $display("FAIL rr_grant: got %b expected %b", req_ready, onehot(order));
      else passes++;
      @(posedge clk);
      #1 model_edge(order);
      checks++;
      if ({rsp_valid, rsp_id, rsp_sum, rsp_carry} !== {1'b1, 2'(order), 4'(m_sum), 1'(m_carry)})
        $display("FAIL rr_rsp: got v=%0b id=%0d sum=%0d c=%0b expected v=1 id=%0d sum=%0d c=%0d",
                 rsp_valid, rsp_id, rsp_sum, rsp_carry, order, m_sum, m_carry);
      else passes++;
      new_operands(order);
    end
  endtask

  task automatic test_overflow();
    logic [W-1:0] exp_sum;
`ifdef ADDER_ARB_SATURATE_EN
    exp_sum = 4'd15;
`else
    exp_sum = 4'd2;
`endif
    req_valid        = 4'b0100;
    req_a[2*W +: W]  = 4'd9;
    req_b[2*W +: W]  = 4'd9;
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0100) $display("FAIL ovf_grant: got %b expected 0100", req_ready);
    else passes++;
    @(posedge clk);
    #1 model_edge(2);
    checks++;
    if ({rsp_valid, rsp_id, rsp_sum, rsp_carry} !== {1'b1, 2'd2, exp_sum, 1'b1})
      $display("FAIL ovf_rsp: got v=%0b id=%0d sum=%0d c=%0b expected v=1 id=2 sum=%0d c=1",
               rsp_valid, rsp_id, rsp_sum, rsp_carry, exp_sum);
    else passes++;
    new_operands(2);
  endtask

  task automatic test_backpressure();
    int g;
    rsp_ready = 1'b0;
    req_valid = '1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if (req_ready !== 4'b0000) $display("FAIL bp_no_grant: got %b expected 0000", req_ready);
      else passes++;
      @(posedge clk);
      #1 model_edge(-1);
      checks++;
      if ({rsp_valid, rsp_id, rsp_sum, rsp_carry} !== {1'b1, 2'(m_id), 4'(m_sum), 1'(m_carry)})
        $display("FAIL bp_hold: got v=%0b id=%0d sum=%0d c=%0b expected v=1 id=%0d sum=%0d c=%0d",
                 rsp_valid, rsp_id, rsp_sum, rsp_carry, m_id, m_sum, m_carry);
      else passes++;
    end
    rsp_ready = 1'b1;
    g = pick(req_valid, m_last);
    @(negedge clk);
    checks++;
    if (req_ready !== onehot(g)) $display("FAIL bp_release: got %b expected %b", req_ready, onehot(g));
    else passes++;
    @(posedge clk);
    #1 model_edge(g);
    checks++;
    if ({rsp_valid, rsp_id, rsp_sum, rsp_carry} !== {1'b1, 2'(g), 4'(m_sum), 1'(m_carry)})
      $display("FAIL bp_new_rsp: got v=%0b id=%0d sum=%0d c=%0b expected v=1 id=%0d sum=%0d c=%0d",
               rsp_valid, rsp_id, rsp_sum, rsp_carry, g, m_sum, m_carry);
    else passes++;
    new_operands(g);
  endtask

  task automatic test_wrap();
    logic [N-1:0] exp_seq [3];
    exp_seq[0] = 4'b1000;
    exp_seq[1] = 4'b0010;
    exp_seq[2] = 4'b1000;
    rsp_ready  = 1'b1;
    req_valid  = 4'b1000;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (req_ready !== exp_seq[c])
        $display("FAIL wrap_grant%0d: got %b expected %b", c, req_ready, exp_seq[c]);
      else passes++;
      @(posedge clk);
      #1 model_edge(exp_grant_from(exp_seq[c]));
      checks++;
      if ({rsp_valid, rsp_id, rsp_sum, rsp_carry} !== {1'b1, 2'(m_id), 4'(m_sum), 1'(m_carry)})
        $display("FAIL wrap_rsp%0d: got v=%0b id=%0d sum=%0d c=%0b expected v=1 id=%0d sum=%0d c=%0d",
                 c, rsp_valid, rsp_id, rsp_sum, rsp_carry, m_id, m_sum, m_carry);
      else passes++;
      for (int k = 0; k < N; k++) if (exp_seq[c][k]) new_operands(k);
      req_valid = 4'b1010;
    end
  endtask

  function automatic int exp_grant_from(input logic [N-1:0] oh);
    for (int k = 0; k < N; k++) if (oh[k]) return k;
    return -1;
  endfunction

  task automatic test_async_reset();
    int g;
    req_valid = '1;
    rsp_ready = 1'b0;
    g = exp_grant();
    @(posedge clk);
    #1 model_edge(g);
    checks++;
    if (rsp_valid !== 1'b1) $display("FAIL ar_full: got %0b expected 1", rsp_valid);
    else passes++;
    #2 rst = 1'b1;
    #1;
    checks++;
    if (rsp_valid !== 1'b0) $display("FAIL ar_async_drop: got %0b expected 0", rsp_valid);
    else passes++;
    @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    rsp_ready = 1'b1;
    checks++;
    if (rsp_valid !== 1'b0) $display("FAIL ar_no_stale: got %0b expected 0", rsp_valid);
    else passes++;
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0001) $display("FAIL ar_priority: got %b expected 0001", req_ready);
    else passes++;
    @(posedge clk);
    #1 model_edge(0);
    checks++;
    if ({rsp_valid, rsp_id, rsp_sum, rsp_carry} !== {1'b1, 2'd0, 4'(m_sum), 1'(m_carry)})
      $display("FAIL ar_rsp: got v=%0b id=%0d sum=%0d c=%0b expected v=1 id=0 sum=%0d c=%0d",
               rsp_valid, rsp_id, rsp_sum, rsp_carry, m_sum, m_carry);
    else passes++;
    new_operands(0);
  endtask

  task automatic test_random();
    int g;
    int wait_cnt [N];
    logic [N-1:0] v_before;
    for (int k = 0; k < N; k++) wait_cnt[k] = 0;
    for (int c = 0; c < 400; c++) begin
      g = exp_grant();
      @(negedge clk);
      checks++;
      if (req_ready !== onehot(g))
        $display("FAIL rand_grant c%0d: got %b expected %b", c, req_ready, onehot(g));
      else passes++;
      v_before = req_valid;
      @(posedge clk);
      #1 model_edge(g);
      checks++;
      if (rsp_valid !== m_full)
        $display("FAIL rand_valid c%0d: got %0b expected %0b", c, rsp_valid, m_full);
      else passes++;
      if (m_full) begin
        checks++;
        if ({rsp_id, rsp_sum, rsp_carry} !== {2'(m_id), 4'(m_sum), 1'(m_carry)})
          $display("FAIL rand_data c%0d: got id=%0d sum=%0d c=%0b expected id=%0d sum=%0d c=%0d",
                   c, rsp_id, rsp_sum, rsp_carry, m_id, m_sum, m_carry);
        else passes++;
      end
      if (g >= 0) begin
        checks++;
        if (wait_cnt[g] >= N)
          $display("FAIL rand_fair: req %0d waited %0d grants, limit %0d", g, wait_cnt[g], N - 1);
        else passes++;
        for (int k = 0; k < N; k++) begin
          if (k == g || !v_before[k]) wait_cnt[k] = 0;
          else wait_cnt[k]++;
        end
      end
      // A pending requester holds its request; granted or idle ones re-roll.
      for (int k = 0; k < N; k++) begin
        if (k == g || !req_valid[k]) begin
          req_valid[k] = 1'($urandom_range(0, 1));
          new_operands(k);
        end
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
    end
  endtask

  initial begin
    test_reset();
    test_first_grant();
    test_round_robin();
    test_overflow();
    test_backpressure();
    test_wrap();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
